fifo_rd_sched: RTL and testbench

FIFO_RD_SCHED -- requirements
Module: fifo_rd_sched

---
 rtl/fifo_rd_sched_if.sv | 29 ++
 rtl/fifo_rd_sched.sv | 107 ++++++++++
 tb/tb_fifo_rd_sched.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_sched_if.sv
// Burst read scheduler bus: two requesters, show-ahead FIFO read side, downstream port.
interface fifo_rd_sched_if #(
  parameter int DATAWIDTH = 64,
  parameter int LENW      = 8
);
  logic                 req0, req1;
  logic [LENW-1:0]      len0, len1;
  logic                 gnt0, gnt1;
  logic                 abort;
  logic                 rempty;
  logic [DATAWIDTH-1:0] rdata;
  logic                 ren;
  logic                 dout_rdy;
  logic [DATAWIDTH-1:0] dout;
  logic                 dout_vld, dout_id, dout_last;
  logic                 busy, done;

  // Scheduler side
  modport slave (
    input  req0, req1, len0, len1, abort, rempty, rdata, dout_rdy,
    output gnt0, gnt1, ren, dout, dout_vld, dout_id, dout_last, busy, done
  );

  // Requesters / FIFO / downstream side
  modport master (
    output req0, req1, len0, len1, abort, rempty, rdata, dout_rdy,
    input  gnt0, gnt1, ren, dout, dout_vld, dout_id, dout_last, busy, done
  );
endinterface

// File: rtl/fifo_rd_sched.sv
// Two-requester burst read scheduler: arbitrates, pops a granted number of
// words from a show-ahead FIFO and forwards them with a one-cycle register.
module fifo_rd_sched #(
  parameter int DATAWIDTH = 64,
  parameter int LENW      = 8
) (
  input  logic            rclk,
  input  logic            rrst,
  fifo_rd_sched_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

  state_t               state, nxt;
  logic [1:0]           req, gnt_c;
  logic                 win;
  logic                 pop;
  logic [LENW-1:0]      rem;
  logic                 id_q;
  logic                 last_id, have_last;
  logic [DATAWIDTH-1:0] dout_q;
  logic                 vld_q, last_q;

  assign req = {bus.req1, bus.req0};

  // Tie goes to whoever was not served last; before any completed burst, requester 0
  always_comb begin
    win = 1'b0;
    unique case (req)
      2'b10:   win = 1'b1;
      2'b11:   win = have_last ? ~last_id : 1'b0;
      default: win = 1'b0;
    endcase
  end

  // Pop only while bursting with data, space, words left and no abort
  assign pop = (state == BURST) && !bus.rempty && bus.dout_rdy &&
               (rem != '0) && !bus.abort;

  // Next state and grant pulse
  always_comb begin
    nxt   = state;
    gnt_c = 2'b00;
    unique case (state)
      IDLE: if (|req) begin
        nxt        = BURST;
        gnt_c[win] = 1'b1;
      end
      BURST: if (bus.abort || (rem == '0) || (pop && rem == LENW'(1))) nxt = DONE;
      DONE:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) state <= IDLE;
    else      state <= nxt;
  end

  // Remaining count and owner latch at grant; count down on each pop
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rem  <= '0;
      id_q <= 1'b0;
    end else if (state == IDLE && (|req)) begin
      rem  <= win ? bus.len1 : bus.len0;
      id_q <= win;
    end else if (pop) begin
      rem  <= rem - LENW'(1);
    end
  end

  // Output register: popped word appears exactly one cycle later
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      dout_q <= '0;
      vld_q  <= 1'b0;
      last_q <= 1'b0;
    end else begin
      vld_q  <= pop;
      last_q <= pop && (rem == LENW'(1));
      if (pop) dout_q <= bus.rdata;
    end
  end

  // Remember who finished last for tie fairness
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      last_id   <= 1'b0;
      have_last <= 1'b0;
    end else if (state == DONE) begin
      last_id   <= id_q;
      have_last <= 1'b1;
    end
  end

  // Grant is combinational in IDLE, so it must be masked while reset is held
  assign bus.gnt0      = gnt_c[0] & ~rrst;
  assign bus.gnt1      = gnt_c[1] & ~rrst;
  assign bus.ren       = pop;
  assign bus.dout      = dout_q;
  assign bus.dout_vld  = vld_q;
  assign bus.dout_last = last_q;
  assign bus.dout_id   = id_q;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
endmodule

// File: tb/tb_fifo_rd_sched.sv
// Bench for fifo_rd_sched: burst table, directed corner sequences, random run
// against a transaction-level reference model.
module tb_fifo_rd_sched;
  localparam int DW = 64;
  localparam int LW = 8;

  logic rclk = 1'b0;
  logic rrst;

  fifo_rd_sched_if #(.DATAWIDTH(DW), .LENW(LW)) bus();
  fifo_rd_sched #(.DATAWIDTH(DW), .LENW(LW)) dut (.rclk(rclk), .rrst(rrst), .bus(bus.slave));

  always #5 rclk = ~rclk;

  int nvec = 0;
  int nmis = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // FIFO model (show-ahead)
  logic [DW-1:0] fq[$];
  logic          ren_q = 1'b0;
  int            cyc_n = 0;

  function automatic void upd();
    bus.rempty = (fq.size() == 0);
    bus.rdata  = (fq.size() != 0) ? fq[0] : '0;
  endfunction

  function automatic void push(input logic [DW-1:0] w);
    fq.push_back(w);
    upd();
  endfunction

  always @(posedge rclk) begin
    cyc_n++;
    #1;
    if (ren_q && fq.size() != 0) void'(fq.pop_front());
    upd();
  end

  // Event logs
  typedef struct { int c; logic id; } gev_t;
  typedef struct { int c; logic [DW-1:0] d; logic id; logic last; } vev_t;
  gev_t gl[$];
  vev_t vl[$];
  int   dl[$];
  int   rl[$];
  bit   log_on = 1'b0;

  always @(negedge rclk) begin
    ren_q = bus.ren;
    if (log_on && !rrst) begin
      if (bus.gnt0)     gl.push_back('{cyc_n, 1'b0});
      if (bus.gnt1)     gl.push_back('{cyc_n, 1'b1});
      if (bus.dout_vld) vl.push_back('{cyc_n, bus.dout, bus.dout_id, bus.dout_last});
      if (bus.done)     dl.push_back(cyc_n);
      if (bus.ren)      rl.push_back(cyc_n);
    end
  end

  function automatic void clr();
    gl.delete(); vl.delete(); dl.delete(); rl.delete();
  endfunction

  task automatic wc(input int n);
    repeat (n) @(posedge rclk);
    #2;
  endtask

  task automatic idle_in();
    bus.req0 = 0; bus.req1 = 0; bus.len0 = '0; bus.len1 = '0;
    bus.abort = 0; bus.dout_rdy = 1;
  endtask

  task automatic do_reset();
    rrst = 1'b1;
    idle_in();
    fq.delete();
    upd();
    wc(2);
    chk("rst_ctl", {bus.ren, bus.gnt0, bus.gnt1, bus.dout_vld, bus.dout_last, bus.done, bus.busy}, 0);
    chk("rst_dout", bus.dout, 0);
    chk("rst_id", bus.dout_id, 0);
    rrst = 1'b0;
  endtask

  task automatic grant(input bit r0, input bit r1, input int l0, input int l1);
    bus.req0 = r0; bus.req1 = r1; bus.len0 = LW'(l0); bus.len1 = LW'(l1);
    wc(1);
    bus.req0 = 0; bus.req1 = 0;
  endtask

  task automatic wait_done(input int lim, input string nm);
    int t = 0;
    while (dl.size() == 0 && t < lim) begin wc(1); t++; end
    chk({nm, "_timeout"}, dl.size() != 0, 1);
  endtask

  function automatic int nlast();
    int n = 0;
    foreach (vl[i]) if (vl[i].last) n++;
    return n;
  endfunction

  // Table of single bursts, applied back to back after one reset
  typedef struct { bit r0; bit r1; int l0; int l1; int nfill; bit eid; int en; } tv_t;
  tv_t tv[6];

  // Reference model state for the random run
  logic [DW-1:0] sb[$];
  bit m_busy, have, lastid, cid;
  int clen, cnt;

  task automatic model_step();
    logic [1:0]    eg;
    logic          w;
    logic [DW-1:0] ew;
    eg = 2'b00;
    w  = 1'b0;
    chk("rnd_busy", bus.busy, m_busy);
    if (!m_busy && (bus.req0 || bus.req1)) begin
      w = (bus.req0 && bus.req1) ? (have ? !lastid : 1'b0) : bus.req1;
      eg[w] = 1'b1;
    end
    chk("rnd_gnt", {bus.gnt1, bus.gnt0}, eg);
    if (eg != 2'b00) begin
      m_busy = 1; cid = w; clen = w ? int'(bus.len1) : int'(bus.len0); cnt = 0;
    end
    if (bus.dout_vld) begin
      ew = (sb.size() != 0) ? sb.pop_front() : '0;
      chk("rnd_data", bus.dout, ew);
      chk("rnd_id", bus.dout_id, cid);
      chk("rnd_last", bus.dout_last, (cnt + 1 == clen));
      cnt++;
    end
    if (bus.done) begin
      chk("rnd_cnt", cnt, clen);
      lastid = cid; have = 1; m_busy = 0;
    end
  endtask

  initial begin
    int g, t;
    logic [DW-1:0] w;
    tv[0] = '{1, 1, 2,   3,   4, 0, 2};
    tv[1] = '{1, 1, 3,   2,   4, 1, 2};
    tv[2] = '{1, 0, 0,   5,   2, 0, 0};
    tv[3] = '{0, 1, 9, 255, 255, 1, 255};
    tv[4] = '{1, 1, 1,   1,   3, 0, 1};
    tv[5] = '{0, 1, 4,   1,   1, 1, 1};
    rrst = 1'b1;
    idle_in();
    upd();

    // Table-driven bursts
    do_reset();
    log_on = 1;
    for (int i = 0; i < 6; i++) begin
      clr();
      fq.delete();
      for (int k = 0; k < tv[i].nfill; k++) push(DW'(32'h1000 * i + k));
      grant(tv[i].r0, tv[i].r1, tv[i].l0, tv[i].l1);
      wait_done(600, $sformatf("tv%0d", i));
      chk($sformatf("tv%0d_id", i), (gl.size() == 1) ? gl[0].id : 1'bx, tv[i].eid);
      chk($sformatf("tv%0d_nw", i), vl.size(), tv[i].en);
      chk($sformatf("tv%0d_nlast", i), nlast(), (tv[i].en > 0) ? 1 : 0);
      if (tv[i].en > 0 && vl.size() == tv[i].en)
        chk($sformatf("tv%0d_lastpos", i), vl[tv[i].en-1].last, 1);
      chk($sformatf("tv%0d_left", i), fq.size(), tv[i].nfill - tv[i].en);
    end

    // Basic 4-word burst with exact timing
    do_reset(); clr();
    for (int i = 0; i < 4; i++) push(DW'('hA0 + i));
    grant(1, 0, 4, 0);
    wait_done(40, "s1");
    g = (gl.size() != 0) ? gl[0].c : -100;
    chk("s1_ngnt", gl.size(), 1);
    chk("s1_nren", rl.size(), 4);
    if (rl.size() == 4) chk("s1_ren_span", {rl[0] - g, rl[3] - g}, {32'd1, 32'd4});
    chk("s1_nvld", vl.size(), 4);
    for (int i = 0; i < 4 && i < vl.size(); i++) begin
      chk($sformatf("s1_d%0d", i), vl[i].d, 'hA0 + i);
      chk($sformatf("s1_c%0d", i), vl[i].c - g, 2 + i);
      chk($sformatf("s1_l%0d", i), vl[i].last, i == 3);
    end
    chk("s1_done", (dl.size() != 0) ? dl[0] - g : -1, 5);

    // Both requesting: alternate 0,1,0,1
    do_reset(); clr();
    for (int i = 0; i < 8; i++) push(DW'('hD0 + i));
    bus.req0 = 1; bus.req1 = 1; bus.len0 = 2; bus.len1 = 2;
    t = 0;
    while (gl.size() < 4 && t < 80) begin wc(1); t++; end
    bus.req0 = 0; bus.req1 = 0;
    while (dl.size() < 4 && t < 120) begin wc(1); t++; end
    chk("s2_ngnt", gl.size(), 4);
    for (int i = 0; i < 4 && i < gl.size(); i++) chk($sformatf("s2_g%0d", i), gl[i].id, i % 2);
    chk("s2_nvld", vl.size(), 8);
    for (int i = 0; i < 8 && i < vl.size(); i++) begin
      chk($sformatf("s2_id%0d", i), vl[i].id, (i / 2) % 2);
      chk($sformatf("s2_d%0d", i), vl[i].d, 'hD0 + i);
    end

    // Stall on empty FIFO, refill later
    do_reset(); clr();
    push(DW'('hB0));
    grant(0, 1, 0, 3);
    g = (gl.size() != 0) ? gl[0].c : -100;
    wc(5);
    push(DW'('hB1)); push(DW'('hB2));
    wait_done(40, "s3");
    chk("s3_nren", rl.size(), 3);
    if (rl.size() == 3) chk("s3_resume", rl[1] - g, 6);
    chk("s3_nvld", vl.size(), 3);
    for (int i = 0; i < 3 && i < vl.size(); i++) begin
      chk($sformatf("s3_d%0d", i), vl[i].d, 'hB0 + i);
      chk($sformatf("s3_id%0d", i), vl[i].id, 1);
      chk($sformatf("s3_l%0d", i), vl[i].last, i == 2);
    end

    // Abort after 3 pops
    do_reset(); clr();
    for (int i = 0; i < 8; i++) push(DW'('hC0 + i));
    grant(1, 0, 8, 0);
    g = (gl.size() != 0) ? gl[0].c : -100;
    wc(3);
    bus.abort = 1;
    wc(1);
    bus.abort = 0;
    wait_done(20, "s4");
    chk("s4_nvld", vl.size(), 3);
    chk("s4_nlast", nlast(), 0);
    chk("s4_done", (dl.size() == 1) ? dl[0] - g : -1, 5);
    chk("s4_left", fq.size(), 5);
    chk("s4_head", (fq.size() != 0) ? fq[0] : '0, 'hC3);

    // Zero-length burst
    do_reset(); clr();
    push(DW'('hE0));
    grant(1, 0, 0, 0);
    g = (gl.size() != 0) ? gl[0].c : -100;
    wait_done(10, "s5");
    chk("s5_ngnt", gl.size(), 1);
    chk("s5_nren", rl.size(), 0);
    chk("s5_nvld", vl.size(), 0);
    chk("s5_done", (dl.size() != 0) ? dl[0] - g : -1, 2);
    chk("s5_left", fq.size(), 1);

    // Reset mid-burst, then tie goes back to requester 0
    do_reset(); clr();
    push(DW'('hF0));
    grant(1, 0, 1, 0);
    wait_done(10, "s6a");
    for (int i = 1; i <= 6; i++) push(DW'('hF0 + i));
    clr();
    grant(1, 0, 6, 0);
    wc(1);
    chk("s6_ren_pre", bus.ren, 1);
    rrst = 1'b1;
    #1;
    chk("s6_ctl", {bus.ren, bus.gnt0, bus.gnt1, bus.dout_vld, bus.dout_last, bus.done, bus.busy}, 0);
    chk("s6_dout", {bus.dout, 1'b0}, 0);
    chk("s6_id", bus.dout_id, 0);
    wc(2);
    chk("s6_left", fq.size(), 5);
    clr();
    bus.req0 = 1; bus.req1 = 1; bus.len0 = 1; bus.len1 = 1;
    rrst = 1'b0;
    #2;
    chk("s6_busy", bus.busy, 0);
    chk("s6_gnt", {bus.gnt1, bus.gnt0}, 2'b01);
    wc(1);
    bus.req0 = 0; bus.req1 = 0;
    wait_done(10, "s6b");
    chk("s6_word", (vl.size() != 0) ? vl[0].d : '0, 'hF2);

    // Random run against the reference model
    do_reset();
    log_on = 0;
    sb.delete();
    m_busy = 0; have = 0; lastid = 0; cid = 0; clen = 0; cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(3) == 0) bus.req0 = 1'($urandom_range(1));
      if ($urandom_range(3) == 0) bus.req1 = 1'($urandom_range(1));
      bus.len0 = LW'($urandom_range(5));
      bus.len1 = LW'($urandom_range(5));
      bus.dout_rdy = ($urandom_range(3) != 0);
      if (fq.size() < 16 && $urandom_range(1) == 1) begin
        w = {$urandom, $urandom};
        push(w);
        sb.push_back(w);
      end
      #2;
      model_step();
      wc(1);
    end
    bus.req0 = 0; bus.req1 = 0; bus.dout_rdy = 1;
    t = 0;
    while (t < 300) begin
      if (fq.size() < 16) begin
        w = {$urandom, $urandom};
        push(w);
        sb.push_back(w);
      end
      #2;
      model_step();
      wc(1);
      t++;
    end
    chk("rnd_drain", bus.busy, 0);
    chk("rnd_model_idle", m_busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    nmis++;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $fatal(1, "watchdog");
  end
endmodule
